// File: rtl/cse141l_pkg.sv
// Shared definitions for the register-file writeback path: widths, the queue
// entry layout and a destination-decode helper.
package cse141l_pkg;

   localparam int REG_W   = 8;
   localparam int NUM_DST = 4;
   localparam int DST_AW  = $clog2(NUM_DST);

   typedef struct packed {
      logic [DST_AW-1:0] rd;
      logic [REG_W-1:0]  data;
   } wb_entry_t;

   function automatic logic [NUM_DST-1:0] dst_onehot(input logic [DST_AW-1:0] rd);
      logic [NUM_DST-1:0] m;
      m     = {NUM_DST{1'b0}};
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry FIFO of writeback entries with flush. Exposes the
// post-update valid vector and contents so the owner can register summaries.
module wb_fifo
   import cse141l_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  wb_entry_t                  push_entry,
   input  logic                       pop,
   output wb_entry_t                  head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [DEPTH-1:0]           valid_next,
   output wb_entry_t [DEPTH-1:0]      entry_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok_s, pop_ok_s;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == CW'(0));
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign valid_next = valid_d;
   assign entry_next = mem_d;

   // Next-state: flush clears everything; otherwise guarded push/pop, pointers wrap mod DEPTH.
   always_comb begin
      mem_d     = mem_q;
      valid_d   = valid_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      if (flush) begin
         valid_d  = {DEPTH{1'b0}};
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (pop_ok_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_ok_s) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         valid_q  <= {DEPTH{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the register-file write port: ALU-priority
// arbitration, in-order drain and a registered per-destination pending mask.
module reg_writeback_queue
   import cse141l_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     alu_valid,
   input  logic [DST_AW-1:0]        alu_rd,
   input  logic [REG_W-1:0]         alu_data,
   output logic                     alu_ready,
   input  logic                     ld_valid,
   input  logic [DST_AW-1:0]        ld_rd,
   input  logic [REG_W-1:0]         ld_data,
   output logic                     ld_ready,
   input  logic                     wr_hold,
   output logic                     wr_en,
   output logic [DST_AW-1:0]        wr_addr,
   output logic [REG_W-1:0]         wr_data,
   output logic [NUM_DST-1:0]       pend_mask,
   output logic [$clog2(DEPTH):0]   q_count
);

   wb_entry_t                 push_entry_s;
   wb_entry_t                 head_s;
   wb_entry_t [DEPTH-1:0]     entry_next_s;
   logic [DEPTH-1:0]          valid_next_s;
   logic                      full_s, empty_s, push_s;
   logic [NUM_DST-1:0]        pend_mask_q, pend_mask_d;

   // rst_n gating makes readies and wr_en drop the instant reset asserts.
   assign alu_ready = rst_n & alu_valid & ~full_s & ~flush;
   assign ld_ready  = rst_n & ld_valid & ~alu_valid & ~full_s & ~flush;
   assign push_s    = alu_ready | ld_ready;
   assign wr_en     = rst_n & ~empty_s & ~wr_hold & ~flush;
   assign wr_addr   = head_s.rd;
   assign wr_data   = head_s.data;
   assign pend_mask = pend_mask_q;

   // Select the accepted producer's result.
   always_comb begin
      push_entry_s = '0;
      if (alu_ready) begin
         push_entry_s.rd   = alu_rd;
         push_entry_s.data = alu_data;
      end else begin
         push_entry_s.rd   = ld_rd;
         push_entry_s.data = ld_data;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (wr_en),
      .head       (head_s),
      .count      (q_count),
      .full       (full_s),
      .empty      (empty_s),
      .valid_next (valid_next_s),
      .entry_next (entry_next_s)
   );

   // Pending mask is the OR of destinations over entries still queued after this edge.
   always_comb begin
      pend_mask_d = {NUM_DST{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_next_s[i]) begin
            pend_mask_d = pend_mask_d | dst_onehot(entry_next_s[i].rd);
         end else begin
            pend_mask_d = pend_mask_d;
         end
      end
   end

   // Pending-mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_mask_q <= {NUM_DST{1'b0}};
      end else begin
         pend_mask_q <= pend_mask_d;
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a queue-based model checked every
// cycle plus hand-computed expectations on the written-value sequence.
module tb_reg_writeback_queue;

   logic       clk, rst_n, flush;
   logic       alu_valid, ld_valid, wr_hold;
   logic [1:0] alu_rd, ld_rd;
   logic [7:0] alu_data, ld_data;
   logic       alu_ready, ld_ready, wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] pend_mask;
   logic [2:0] q_count;

   int n_vec  = 0;
   int n_fail = 0;

   logic [9:0] mq[$];    // model queue of {rd, data}
   logic [9:0] wlog[$];  // writes the DUT actually performed

   reg_writeback_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .wr_hold(wr_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pend_mask(pend_mask), .q_count(q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model update from the queueing rules: flush clears, pop head if draining, then accept one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         mq.delete();
      end else begin
         bit       do_pop;
         bit       do_push;
         logic [9:0] e;
         do_pop  = (mq.size() > 0) && !wr_hold;
         do_push = (alu_valid || ld_valid) && (mq.size() < 4);
         e       = alu_valid ? {alu_rd, alu_data} : {ld_rd, ld_data};
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
   end

   // Per-cycle compare against the model; also log writes that the coming edge performs.
   always @(negedge clk) begin
      bit       full, e_wr;
      logic [3:0] e_pend;
      full   = (mq.size() == 4);
      e_wr   = rst_n && (mq.size() > 0) && !wr_hold && !flush;
      e_pend = 4'b0000;
      foreach (mq[i]) e_pend = e_pend | (4'b0001 << mq[i][9:8]);
      chk("alu_ready", alu_ready, rst_n && alu_valid && !full && !flush);
      chk("ld_ready", ld_ready, rst_n && ld_valid && !alu_valid && !full && !flush);
      chk("wr_en", wr_en, e_wr);
      chk("q_count", q_count, mq.size());
      chk("pend_mask", pend_mask, e_pend);
      if (e_wr) begin
         chk("wr_addr", wr_addr, mq[0][9:8]);
         chk("wr_data", wr_data, mq[0][7:0]);
      end
      if (!rst_n) begin
         chk("rst_wr_addr", wr_addr, 2'd0);
         chk("rst_wr_data", wr_data, 8'h00);
      end
      if (wr_en) wlog.push_back({wr_addr, wr_data});
   end

   task automatic chk_log(input int idx, input logic [9:0] exp);
      if (idx < wlog.size()) chk("wlog_entry", wlog[idx], exp);
      else chk("wlog_missing", 32'hDEAD, exp);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; wr_hold = 1'b0;
      alu_valid = 1'b0; alu_rd = 2'd0; alu_data = 8'h00;
      ld_valid = 1'b0; ld_rd = 2'd0; ld_data = 8'h00;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single ALU result
      wlog.delete();
      alu_valid = 1'b1; alu_rd = 2'd2; alu_data = 8'h5A;
      tick();
      alu_valid = 1'b0;
      #1;
      chk("t2_wr_en", wr_en, 1'b1);
      chk("t2_wr_addr", wr_addr, 2'd2);
      chk("t2_wr_data", wr_data, 8'h5A);
      chk("t2_pend", pend_mask, 4'b0100);
      tick();
      chk("t2_pend_clr", pend_mask, 4'b0000);
      chk("t2_wr_en_off", wr_en, 1'b0);
      chk("t2_log_n", wlog.size(), 1);
      chk_log(0, {2'd2, 8'h5A});

      // ALU priority over load
      wlog.delete();
      alu_valid = 1'b1; alu_rd = 2'd1; alu_data = 8'h11;
      ld_valid = 1'b1; ld_rd = 2'd3; ld_data = 8'h33;
      #1;
      chk("t3_alu_rdy", alu_ready, 1'b1);
      chk("t3_ld_rdy", ld_ready, 1'b0);
      tick();
      alu_valid = 1'b0;
      #1;
      chk("t3_ld_rdy2", ld_ready, 1'b1);
      chk("t3_wr11", wr_data, 8'h11);
      tick();
      ld_valid = 1'b0;
      #1;
      chk("t3_wr33", wr_data, 8'h33);
      tick(); tick();
      chk("t3_log_n", wlog.size(), 2);
      chk_log(0, {2'd1, 8'h11});
      chk_log(1, {2'd3, 8'h33});

      // Fill under hold, then drain
      wlog.delete();
      wr_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 2'(i); alu_data = 8'h40 + 8'(i);
         tick();
      end
      alu_rd = 2'd1; alu_data = 8'h44;
      #1;
      chk("t4_count4", q_count, 3'd4);
      chk("t4_pend_all", pend_mask, 4'b1111);
      chk("t4_full_rdy", alu_ready, 1'b0);
      tick();
      chk("t4_count_hold", q_count, 3'd4);
      wr_hold = 1'b0;
      #1;
      chk("t4_rdy_still0", alu_ready, 1'b0);
      chk("t4_wr_en", wr_en, 1'b1);
      tick();
      chk("t4_rdy_rise", alu_ready, 1'b1);
      chk("t4_count3", q_count, 3'd3);
      tick();
      alu_valid = 1'b0;
      tick(); tick(); tick();
      chk("t4_empty", q_count, 3'd0);
      chk("t4_log_n", wlog.size(), 5);
      chk_log(0, {2'd0, 8'h40});
      chk_log(1, {2'd1, 8'h41});
      chk_log(2, {2'd2, 8'h42});
      chk_log(3, {2'd3, 8'h43});
      chk_log(4, {2'd1, 8'h44});

      // Same destination twice
      wlog.delete();
      wr_hold = 1'b1;
      alu_valid = 1'b1; alu_rd = 2'd0; alu_data = 8'hA0;
      tick();
      alu_data = 8'hA1;
      tick();
      alu_valid = 1'b0; wr_hold = 1'b0;
      #1;
      chk("t5_pend_a", pend_mask, 4'b0001);
      chk("t5_wrA0", wr_data, 8'hA0);
      tick();
      chk("t5_pend_b", pend_mask, 4'b0001);
      chk("t5_wrA1", wr_data, 8'hA1);
      tick();
      chk("t5_pend_clr", pend_mask, 4'b0000);
      chk("t5_log_n", wlog.size(), 2);
      chk_log(0, {2'd0, 8'hA0});
      chk_log(1, {2'd0, 8'hA1});

      // Flush with three queued
      wlog.delete();
      wr_hold = 1'b1;
      for (int i = 1; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 2'(i); alu_data = 8'h60 + 8'(i);
         tick();
      end
      alu_rd = 2'd0; alu_data = 8'h70;
      wr_hold = 1'b0; flush = 1'b1;
      #1;
      chk("t6_wr_en", wr_en, 1'b0);
      chk("t6_alu_rdy", alu_ready, 1'b0);
      chk("t6_count3", q_count, 3'd3);
      tick();
      flush = 1'b0;
      #1;
      chk("t6_count0", q_count, 3'd0);
      chk("t6_pend0", pend_mask, 4'b0000);
      chk("t6_rdy", alu_ready, 1'b1);
      tick();
      alu_valid = 1'b0;
      #1;
      chk("t6_wr_en2", wr_en, 1'b1);
      chk("t6_wr70", wr_data, 8'h70);
      chk("t6_pend1", pend_mask, 4'b0001);
      tick();
      chk("t6_log_n", wlog.size(), 1);
      chk_log(0, {2'd0, 8'h70});

      // Asynchronous reset with three queued
      wlog.delete();
      wr_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 2'(i); alu_data = 8'hB0 + 8'(i);
         tick();
      end
      alu_valid = 1'b0; wr_hold = 1'b0;
      #1;
      chk("t1_wr_en_pre", wr_en, 1'b1);
      chk("t1_count_pre", q_count, 3'd3);
      rst_n = 1'b0;
      #1;
      chk("t1_wr_en", wr_en, 1'b0);
      chk("t1_count", q_count, 3'd0);
      chk("t1_pend", pend_mask, 4'b0000);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("t1_log_n", wlog.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
